// File: rtl/flit_sender.sv
// Router output stage: pops one flit from the input buffer, XY-routes it, and offers it on one outgoing link.
// Latency: a pop follows the edge that sees is_empty low; out_r rises two edges later. One flit per 3 cycles at best.
// Backpressure: holds out_r/data_o in SEND until the selected link's out_w is sampled high; other out_w bits are ignored.
module flit_sender #(
    parameter int DATA_SIZE = 4,
    parameter int ADDR_SIZE = 4,
    parameter int PORTS_NUM = 4,
    parameter int X_COORD   = 1,
    parameter int Y_COORD   = 1
) (
    input  logic                           clk,
    input  logic                           a_rst,
    input  logic                           is_empty,
    input  logic [DATA_SIZE+ADDR_SIZE:0]   data_i,
    output logic                           rd_req,
    input  logic [PORTS_NUM:0]             out_w,
    output logic [PORTS_NUM:0]             out_r,
    output logic [DATA_SIZE+ADDR_SIZE:0]   data_o
);

    localparam int HALF  = ADDR_SIZE / 2;
    localparam int SEL_W = $clog2(PORTS_NUM + 1);

    localparam logic [SEL_W-1:0] PORT_NORTH = SEL_W'(0);
    localparam logic [SEL_W-1:0] PORT_EAST  = SEL_W'(1);
    localparam logic [SEL_W-1:0] PORT_SOUTH = SEL_W'(2);
    localparam logic [SEL_W-1:0] PORT_WEST  = SEL_W'(3);
    localparam logic [SEL_W-1:0] PORT_LOCAL = SEL_W'(PORTS_NUM);

    localparam logic [HALF-1:0]  X_HERE   = HALF'(X_COORD);
    localparam logic [HALF-1:0]  Y_HERE   = HALF'(Y_COORD);
    localparam logic [PORTS_NUM:0] LINK_ONE = (PORTS_NUM+1)'(1);

    typedef struct packed {
        logic                 tail;
        logic [ADDR_SIZE-1:0] addr;
        logic [DATA_SIZE-1:0] data;
    } flit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t           state;
    flit_t            flit_q;
    flit_t            in_flit;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] route_sel;

    // Dimension-ordered: resolve X fully before Y; equal in both means this node.
    function automatic logic [SEL_W-1:0] xy_route(input logic [ADDR_SIZE-1:0] addr);
        logic [HALF-1:0] xd;
        logic [HALF-1:0] yd;
        xd = addr[HALF-1:0];
        yd = addr[ADDR_SIZE-1:HALF];
        if (xd > X_HERE)
            return PORT_EAST;
        else if (xd < X_HERE)
            return PORT_WEST;
        else if (yd > Y_HERE)
            return PORT_SOUTH;
        else if (yd < Y_HERE)
            return PORT_NORTH;
        else
            return PORT_LOCAL;
    endfunction

    assign in_flit   = flit_t'(data_i);
    assign route_sel = xy_route(in_flit.addr);
    assign data_o    = flit_q;

    always_ff @(posedge clk) begin
        if (a_rst) begin
            state  <= IDLE;
            rd_req <= 1'b0;
            out_r  <= '0;
            flit_q <= '0;
            sel_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!is_empty) begin
                        state  <= READ;
                        rd_req <= 1'b1;
                    end
                end
                READ: begin
                    rd_req <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    flit_q <= in_flit;
                    sel_q  <= route_sel;
                    out_r  <= LINK_ONE << route_sel;
                    state  <= SEND;
                end
                SEND: begin
                    // flit_q is left untouched so data_o keeps the last flit after acceptance.
                    if (out_w[sel_q]) begin
                        out_r <= '0;
                        if (!is_empty) begin
                            state  <= READ;
                            rd_req <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    rd_req <= 1'b0;
                    out_r  <= '0;
                end
            endcase
        end
    end

endmodule
